// File: rtl/color_conv_stream.sv
// RGB to YCbCr (BT.601 / BT.709 per pixel) converter, 3-stage multiply / sum / round-clamp pipeline.
// Latency 3 cycles, one pixel per cycle; a single advance enable stalls every stage when the output is held.
module color_conv_stream #(
    parameter int DW = 8,
    parameter int CW = 14,
    parameter int UW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [3*DW-1:0] s_data,
    input  logic            s_mode,
    input  logic [UW-1:0]   s_user,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [3*DW-1:0] m_data,
    output logic [UW-1:0]   m_user
);
    localparam int PW = DW + CW + 3;

    function automatic logic signed [PW-1:0] fx(input real c);
        return PW'($rtoi($floor(c * (2.0 ** CW) + 0.5)));
    endfunction

    // Row-major Y, Cb, Cr; columns R, G, B.
    localparam logic signed [PW-1:0] K601 [9] = '{
        fx(0.299),     fx(0.587),     fx(0.114),
        fx(-0.168736), fx(-0.331264), fx(0.5),
        fx(0.5),       fx(-0.418688), fx(-0.081312)
    };
    localparam logic signed [PW-1:0] K709 [9] = '{
        fx(0.2126),    fx(0.7152),    fx(0.0722),
        fx(-0.114572), fx(-0.385428), fx(0.5),
        fx(0.5),       fx(-0.454153), fx(-0.045847)
    };

    localparam logic signed [PW-1:0] CHROMA_OFS = {{(PW-DW-CW){1'b0}}, 1'b1, {(DW-1+CW){1'b0}}};
    localparam logic signed [PW-1:0] RND        = {{(PW-CW){1'b0}}, 1'b1, {(CW-1){1'b0}}};
    localparam logic signed [PW-1:0] MAXV       = {{(PW-DW){1'b0}}, {DW{1'b1}}};

    function automatic logic [DW-1:0] round_clamp(input logic signed [PW-1:0] s);
        logic signed [PW-1:0] r;
        r = (s + RND) >>> CW;
        if (r[PW-1])
            return '0;
        else if (r > MAXV)
            return '1;
        else
            return r[DW-1:0];
    endfunction

    logic                 advance;
    logic [DW-1:0]        rgb [3];
    logic signed [PW-1:0] coef [9];
    logic signed [PW-1:0] prod [9];

    logic                 v1, v2;
    logic signed [PW-1:0] p1 [9];
    logic [UW-1:0]        u1, u2;
    logic signed [PW-1:0] y2, cb2, cr2;

    assign advance = !m_valid || m_ready;
    assign s_ready = advance;

    assign rgb[0] = s_data[3*DW-1:2*DW];
    assign rgb[1] = s_data[2*DW-1:DW];
    assign rgb[2] = s_data[DW-1:0];

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            coef[i] = s_mode ? K709[i] : K601[i];
            prod[i] = $signed({{(PW-DW){1'b0}}, rgb[i%3]}) * coef[i];
        end
    end

    // Control and output registers: valid bits clear on reset so in-flight pixels are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_user  <= '0;
        end else if (advance) begin
            v1      <= s_valid;
            v2      <= v1;
            m_valid <= v2;
            m_data  <= {round_clamp(cr2), round_clamp(cb2), round_clamp(y2)};
            m_user  <= u2;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            p1  <= prod;
            u1  <= s_user;
            y2  <= p1[0] + p1[1] + p1[2];
            cb2 <= p1[3] + p1[4] + p1[5] + CHROMA_OFS;
            cr2 <= p1[6] + p1[7] + p1[8] + CHROMA_OFS;
            u2  <= u1;
        end
    end

endmodule

// File: tb/tb_color_conv_stream.sv
// Directed bench for color_conv_stream: hand-computed pixels, latency, mode alternation, stalls and reset flush.
module tb_color_conv_stream;
    localparam int DW = 8;
    localparam int CW = 14;
    localparam int UW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_valid;
    logic            s_ready;
    logic [3*DW-1:0] s_data;
    logic            s_mode;
    logic [UW-1:0]   s_user;
    logic            m_valid;
    logic            m_ready;
    logic [3*DW-1:0] m_data;
    logic [UW-1:0]   m_user;

    always #5 clk = ~clk;

    color_conv_stream #(.DW(DW), .CW(CW), .UW(UW)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_mode  (s_mode),
        .s_user  (s_user),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_user  (m_user)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Input RGB, mode and expected {Cr,Cb,Y}, worked out by hand from the fixed-point coefficients.
    logic [23:0] vin  [8] = '{24'hffffff, 24'hff0000, 24'h0000ff, 24'h00ff00,
                              24'h00ff00, 24'h000000, 24'hff0000, 24'h000000};
    logic        vmode[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [23:0] vexp [8] = '{24'h8080ff, 24'hff554c, 24'h6bff1d, 24'h152c96,
                              24'h0c1eb6, 24'h808000, 24'hff6336, 24'h808000};

    int seq_len;
    int seq [16];

    task automatic one_pixel(input string tag, input int idx, input logic [UW-1:0] usr);
        int lat;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = vin[idx];
        s_mode  = vmode[idx];
        s_user  = usr;
        m_ready = 1'b1;
        #1;
        check({tag, "_rdy"}, 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        lat = 1;
        while (!m_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        check({tag, "_dat"}, 32'(m_data), 32'(vexp[idx]));
        check({tag, "_usr"}, 32'(m_user), 32'(usr));
        @(negedge clk);
    endtask

    task automatic run_stream(input string tag, input bit gaps);
        logic [UW+3*DW-1:0] expq [$];
        logic [UW+3*DW-1:0] item;
        logic [UW+3*DW-1:0] held;
        int  in_i = 0;
        int  out_n = 0;
        int  cyc = 0;
        int  first_in = -1;
        int  first_out = -1;
        int  last_out = -1;
        bit  stall = 1'b0;
        bit  holding = 1'b0;
        held = '0;
        while (out_n < seq_len && cyc < 400) begin
            @(negedge clk);
            if (!holding) begin
                s_valid = 1'b0;
                if (in_i < seq_len && (!gaps || $urandom_range(0, 2) != 0)) begin
                    s_valid = 1'b1;
                    s_data  = vin[seq[in_i]];
                    s_mode  = vmode[seq[in_i]];
                    s_user  = UW'(in_i);
                end
            end
            m_ready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (stall) begin
                check({tag, "_hold_vld"}, 32'(m_valid), 32'd1);
                check({tag, "_hold_dat"}, 32'({m_user, m_data}), 32'(held));
            end
            if (m_valid && m_ready) begin
                if (expq.size() == 0) begin
                    check({tag, "_extra"}, 32'(m_valid), 32'd0);
                end else begin
                    item = expq.pop_front();
                    check({tag, "_out"}, 32'({m_user, m_data}), 32'(item));
                    out_n++;
                    if (first_out < 0) first_out = cyc;
                    last_out = cyc;
                end
            end
            stall = m_valid && !m_ready;
            held  = {m_user, m_data};
            if (s_valid && s_ready) begin
                expq.push_back({UW'(in_i), vexp[seq[in_i]]});
                if (first_in < 0) first_in = cyc;
                in_i++;
                holding = 1'b0;
            end else begin
                holding = s_valid;
            end
            cyc++;
        end
        check({tag, "_count"}, 32'(out_n), 32'(seq_len));
        if (!gaps) begin
            check({tag, "_lat"}, 32'(first_out - first_in), 32'd3);
            check({tag, "_b2b"}, 32'(last_out - first_out), 32'(seq_len - 1));
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check({tag, "_drain"}, 32'(m_valid), 32'd0);
        end
    endtask

    initial begin
        int seen;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_mode  = 1'b0;
        s_user  = '0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_vld", 32'(m_valid), 32'd0);
        check("rst_dat", 32'(m_data), 32'd0);
        check("rst_usr", 32'(m_user), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        check("rdy_after_rst", 32'(s_ready), 32'd1);
        m_ready = 1'b1;

        one_pixel("white601", 0, 2'd1);
        one_pixel("red601",   1, 2'd2);
        one_pixel("blue601",  2, 2'd3);
        one_pixel("black601", 5, 2'd0);
        one_pixel("black709", 7, 2'd2);
        one_pixel("red709",   6, 2'd1);

        seq_len = 6;
        for (int i = 0; i < 6; i++) seq[i] = (i % 2 == 0) ? 3 : 4;
        run_stream("alt", 1'b0);

        seq_len = 16;
        for (int i = 0; i < 16; i++) seq[i] = i % 8;
        run_stream("rand", 1'b1);

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = vin[1];
            s_mode  = 1'b0;
            s_user  = UW'(k);
            m_ready = 1'b1;
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
        check("pre_rst_vld", 32'(m_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("flush_vld", 32'(m_valid), 32'd0);
        check("flush_dat", 32'(m_data), 32'd0);
        rst = 1'b0;
        m_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_valid) seen++;
        end
        check("no_stale", 32'(seen), 32'd0);
        one_pixel("post_rst", 2, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
